// File: rtl/ifu_prefetch.sv
// Instruction-fetch unit: issues requests to a 1-cycle-latency instruction RAM,
// buffers responses in a prefetch queue and presents them to decode with valid/ready.
module ifu_prefetch #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        inst_req,
  output logic [ADDR_W-1:0]           inst_addr,
  input  logic [31:0]                 inst_in,
  input  logic                        redirect_valid,
  input  logic [ADDR_W-1:0]           redirect_pc,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ADDR_W-1:0]           out_pc,
  output logic [31:0]                 out_inst,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] pending_pc;
  logic              pending;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] mem_pc   [FIFO_DEPTH];
  logic [31:0]       mem_inst [FIFO_DEPTH];
  logic [CNT_W:0]    used;
  logic              push;
  logic              pop;
  logic              unused_low_bits;

  assign unused_low_bits = ^redirect_pc[1:0];

  // Credit counts the in-flight fetch, so a returning response always has a slot.
  always_comb begin
    used      = {1'b0, cnt} + (CNT_W + 1)'(pending);
    inst_req  = !rst && !redirect_valid && (used < (CNT_W + 1)'(FIFO_DEPTH));
    inst_addr = fetch_pc;
    out_valid = (cnt != '0) && !redirect_valid;
    out_pc    = mem_pc[rd_ptr];
    out_inst  = mem_inst[rd_ptr];
    fifo_cnt  = cnt;
    push      = pending && !redirect_valid;
    pop       = out_valid && out_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc   <= RESET_PC;
      pending_pc <= '0;
      pending    <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      cnt        <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_pc[i]   <= '0;
        mem_inst[i] <= '0;
      end
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
      pending  <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
    end else begin
      pending <= inst_req;
      if (inst_req) begin
        pending_pc <= fetch_pc;
        fetch_pc   <= fetch_pc + ADDR_W'(4);
      end
      if (push) begin
        mem_pc[wr_ptr]   <= pending_pc;
        mem_inst[wr_ptr] <= inst_in;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch: default instance plus a DEPTH=2 instance
// starting near the top of the address space.
module tb_ifu_prefetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  logic        rst = 1'b1, inst_req, redirect_valid = 1'b0, out_valid, out_ready = 1'b0;
  logic [31:0] inst_addr, inst_in, redirect_pc = '0, out_pc, out_inst;
  logic [2:0]  fifo_cnt;

  logic        rst2 = 1'b1, inst_req2, redirect2 = 1'b0, out_valid2, out_ready2 = 1'b0;
  logic [31:0] inst_addr2, inst_in2, redirect_pc2 = '0, out_pc2, out_inst2;
  logic [1:0]  fifo_cnt2;

  ifu_prefetch #(.ADDR_W(32), .RESET_PC(32'h0), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .inst_req(inst_req), .inst_addr(inst_addr), .inst_in(inst_in),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst), .fifo_cnt(fifo_cnt));

  ifu_prefetch #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) u_dut2 (
    .clk(clk), .rst(rst2), .inst_req(inst_req2), .inst_addr(inst_addr2), .inst_in(inst_in2),
    .redirect_valid(redirect2), .redirect_pc(redirect_pc2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_pc(out_pc2), .out_inst(out_inst2), .fifo_cnt(fifo_cnt2));

  // RAM models: data = address; garbage when no request was made.
  always @(posedge clk) inst_in  <= inst_req  ? inst_addr  : 32'hDEAD_BEEF;
  always @(posedge clk) inst_in2 <= inst_req2 ? inst_addr2 : 32'hDEAD_BEEF;

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset(input logic ready);
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = ready;
    next(); next();
    rst = 1'b0; settle();
  endtask

  task automatic test_reset();
    rst = 1'b1; next(); settle();
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset.out_valid got %b want 0", out_valid); end
    vecs++; if (inst_req !== 1'b0) begin errs++; $display("FAIL reset.inst_req got %b want 0", inst_req); end
    vecs++; if (inst_addr !== 32'h0) begin errs++; $display("FAIL reset.inst_addr got %h want 0", inst_addr); end
    vecs++; if (fifo_cnt !== 3'd0) begin errs++; $display("FAIL reset.fifo_cnt got %0d want 0", fifo_cnt); end
    vecs++; if (out_pc !== 32'h0) begin errs++; $display("FAIL reset.out_pc got %h want 0", out_pc); end
    vecs++; if (out_inst !== 32'h0) begin errs++; $display("FAIL reset.out_inst got %h want 0", out_inst); end
  endtask

  task automatic test_stream();
    do_reset(1'b1);
    vecs++; if (inst_req !== 1'b1) begin errs++; $display("FAIL stream.c0_req got %b want 1", inst_req); end
    vecs++; if (inst_addr !== 32'h0) begin errs++; $display("FAIL stream.c0_addr got %h want 0", inst_addr); end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL stream.c0_valid got %b want 0", out_valid); end
    next(); settle();
    vecs++; if (inst_addr !== 32'h4) begin errs++; $display("FAIL stream.c1_addr got %h want 4", inst_addr); end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL stream.c1_valid got %b want 0", out_valid); end
    for (int c = 2; c < 10; c++) begin
      next(); settle();
      vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL stream.valid c%0d got %b want 1", c, out_valid); end
      vecs++; if (out_pc !== 32'((c - 2) * 4)) begin errs++; $display("FAIL stream.pc c%0d got %h want %h", c, out_pc, (c - 2) * 4); end
      vecs++; if (out_inst !== 32'((c - 2) * 4)) begin errs++; $display("FAIL stream.inst c%0d got %h want %h", c, out_inst, (c - 2) * 4); end
      vecs++; if (fifo_cnt !== 3'd1) begin errs++; $display("FAIL stream.cnt c%0d got %0d want 1", c, fifo_cnt); end
    end
  endtask

  task automatic test_backpressure();
    int reqs;
    logic [31:0] exp;
    reqs = 0;
    do_reset(1'b0);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) begin next(); settle(); end
      if (inst_req) reqs++;
    end
    vecs++; if (reqs !== 4) begin errs++; $display("FAIL bp.req_count got %0d want 4", reqs); end
    vecs++; if (fifo_cnt !== 3'd4) begin errs++; $display("FAIL bp.full_cnt got %0d want 4", fifo_cnt); end
    vecs++; if (inst_req !== 1'b0) begin errs++; $display("FAIL bp.full_req got %b want 0", inst_req); end
    vecs++; if (out_pc !== 32'h0) begin errs++; $display("FAIL bp.head got %h want 0", out_pc); end
    out_ready = 1'b1;
    next(); out_ready = 1'b0; settle();
    vecs++; if (inst_req !== 1'b1) begin errs++; $display("FAIL bp.resume_req got %b want 1", inst_req); end
    vecs++; if (inst_addr !== 32'h10) begin errs++; $display("FAIL bp.resume_addr got %h want 10", inst_addr); end
    vecs++; if (fifo_cnt !== 3'd3) begin errs++; $display("FAIL bp.after_pop_cnt got %0d want 3", fifo_cnt); end
    vecs++; if (out_pc !== 32'h4) begin errs++; $display("FAIL bp.after_pop_head got %h want 4", out_pc); end
    out_ready = 1'b1; settle();
    exp = 32'h4;
    for (int k = 0; k < 5; k++) begin
      vecs++; if (out_valid !== 1'b1 || out_pc !== exp || out_inst !== exp) begin
        errs++; $display("FAIL bp.order k%0d got v=%b pc=%h inst=%h want pc=%h", k, out_valid, out_pc, out_inst, exp);
      end
      exp += 32'h4;
      next(); settle();
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    repeat (4) next();
    redirect_valid = 1'b1; redirect_pc = 32'h103; settle();
    vecs++; if (fifo_cnt !== 3'd3) begin errs++; $display("FAIL redir.pre_cnt got %0d want 3", fifo_cnt); end
    vecs++; if (inst_req !== 1'b0) begin errs++; $display("FAIL redir.req got %b want 0", inst_req); end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL redir.valid got %b want 0", out_valid); end
    next(); redirect_valid = 1'b0; settle();
    vecs++; if (fifo_cnt !== 3'd0) begin errs++; $display("FAIL redir.flush_cnt got %0d want 0", fifo_cnt); end
    vecs++; if (inst_addr !== 32'h100) begin errs++; $display("FAIL redir.addr got %h want 100", inst_addr); end
    vecs++; if (inst_req !== 1'b1) begin errs++; $display("FAIL redir.r1_req got %b want 1", inst_req); end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL redir.r1_valid got %b want 0", out_valid); end
    next(); settle();
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL redir.r2_valid got %b want 0", out_valid); end
    next(); out_ready = 1'b1; settle();
    vecs++; if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_inst !== 32'h100) begin
      errs++; $display("FAIL redir.r3_head got v=%b pc=%h inst=%h want pc=100", out_valid, out_pc, out_inst);
    end
    next(); settle();
    vecs++; if (out_valid !== 1'b1 || out_pc !== 32'h104) begin
      errs++; $display("FAIL redir.r4_head got v=%b pc=%h want 104", out_valid, out_pc);
    end
  endtask

  task automatic test_redirect_pop();
    next(); settle();
    vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL rpop.pre_valid got %b want 1", out_valid); end
    redirect_valid = 1'b1; redirect_pc = 32'h200; settle();
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rpop.valid got %b want 0", out_valid); end
    vecs++; if (inst_req !== 1'b0) begin errs++; $display("FAIL rpop.req got %b want 0", inst_req); end
    next(); redirect_valid = 1'b0; settle();
    vecs++; if (fifo_cnt !== 3'd0) begin errs++; $display("FAIL rpop.cnt got %0d want 0", fifo_cnt); end
    vecs++; if (inst_addr !== 32'h200) begin errs++; $display("FAIL rpop.addr got %h want 200", inst_addr); end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rpop.r1_valid got %b want 0", out_valid); end
    next(); settle();
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rpop.r2_valid got %b want 0", out_valid); end
    next(); settle();
    vecs++; if (out_valid !== 1'b1 || out_pc !== 32'h200) begin
      errs++; $display("FAIL rpop.r3_head got v=%b pc=%h want 200", out_valid, out_pc);
    end
  endtask

  task automatic test_pc_wrap();
    logic [31:0] exp [4];
    int got;
    exp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    got = 0;
    rst2 = 1'b1; out_ready2 = 1'b0;
    next(); next(); rst2 = 1'b0; settle();
    vecs++; if (inst_addr2 !== 32'hFFFF_FFF8 || inst_req2 !== 1'b1) begin
      errs++; $display("FAIL wrap.c0 got req=%b addr=%h want 1/fffffff8", inst_req2, inst_addr2);
    end
    repeat (3) next();
    settle();
    vecs++; if (fifo_cnt2 !== 2'd2) begin errs++; $display("FAIL wrap.full_cnt got %0d want 2", fifo_cnt2); end
    vecs++; if (inst_req2 !== 1'b0) begin errs++; $display("FAIL wrap.full_req got %b want 0", inst_req2); end
    vecs++; if (inst_addr2 !== 32'h0) begin errs++; $display("FAIL wrap.fetch_pc got %h want 0", inst_addr2); end
    out_ready2 = 1'b1; settle();
    for (int i = 0; i < 12; i++) begin
      vecs++; if (fifo_cnt2 > 2'd2) begin errs++; $display("FAIL wrap.cnt_bound got %0d want <=2", fifo_cnt2); end
      if (out_valid2 && got < 4) begin
        vecs++; if (out_pc2 !== exp[got] || out_inst2 !== exp[got]) begin
          errs++; $display("FAIL wrap.out%0d got pc=%h inst=%h want %h", got, out_pc2, out_inst2, exp[got]);
        end
        got++;
      end
      next(); settle();
    end
    vecs++; if (got !== 4) begin errs++; $display("FAIL wrap.timeout got %0d outputs want 4", got); end
  endtask

  task automatic test_async_reset();
    do_reset(1'b1);
    next(); next(); out_ready = 1'b0; settle();
    vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL arst.pre_valid got %b want 1", out_valid); end
    #2 rst = 1'b1;
    #1;
    vecs++; if (out_valid !== 1'b0 || inst_req !== 1'b0 || fifo_cnt !== 3'd0) begin
      errs++; $display("FAIL arst.ctl got v=%b req=%b cnt=%0d want 0/0/0", out_valid, inst_req, fifo_cnt);
    end
    vecs++; if (inst_addr !== 32'h0 || out_pc !== 32'h0 || out_inst !== 32'h0) begin
      errs++; $display("FAIL arst.data got addr=%h pc=%h inst=%h want 0", inst_addr, out_pc, out_inst);
    end
    next(); next(); rst = 1'b0; out_ready = 1'b1; settle();
    vecs++; if (out_valid !== 1'b0 || inst_addr !== 32'h0) begin
      errs++; $display("FAIL arst.c0 got v=%b addr=%h want 0/0", out_valid, inst_addr);
    end
    next(); settle();
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL arst.c1_stale got %b want 0", out_valid); end
    next(); settle();
    vecs++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      errs++; $display("FAIL arst.c2 got v=%b pc=%h want 1/0", out_valid, out_pc);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_pop();
    test_pc_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
